// File: rtl/gfifo_pkg.sv
// Shared widths, entry layout and error codes for the difftest step channel.
package gfifo_pkg;

  localparam int unsigned DefStepWidth = 8;
  localparam int unsigned DefCntWidth  = 16;

  typedef struct packed {
    logic [63:0]              cycle;
    logic [DefCntWidth-1:0]   count;
  } gfifo_entry_t;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrHostFail = 2'd1,
    ErrCntSat   = 2'd2,
    ErrProto    = 2'd3
  } gfifo_err_e;

endpackage

// File: rtl/gfifo_sync_fifo.sv
// Generic single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module gfifo_sync_fifo #(
  parameter int unsigned Width = 80,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wr_ptr_q, wr_ptr_d;
  logic [Aw:0]      rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]) && (wr_ptr_q[Aw] != rd_ptr_q[Aw]);
  assign rd_data_o = mem_q[rd_ptr_q[Aw-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{Aw{1'b0}}, wr_en_i};
    rd_ptr_d = rd_ptr_q + {{Aw{1'b0}}, rd_en_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define which slots are live.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q[Aw-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/gfifo_ctrl.sv
// Difftest step channel: coalesces per-cycle commit counts into stamped FIFO entries for the
// host and latches the first host failure or channel error.
module gfifo_ctrl
  import gfifo_pkg::*;
#(
  parameter int unsigned STEP_WIDTH = DefStepWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_OUT    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [STEP_WIDTH-1:0] step,
  output logic                  host_valid,
  input  logic                  host_ready,
  output logic [63:0]           host_cycle,
  output logic [CNT_WIDTH-1:0]  host_count,
  input  logic                  rsp_valid,
  input  logic                  rsp_fail,
  output logic                  simv_result,
  output logic [1:0]            err_code
);

  localparam int unsigned EntryW = 64 + CNT_WIDTH;
  localparam int unsigned SumW   = CNT_WIDTH + 1;
  localparam int unsigned OutW   = $clog2(MAX_OUT + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUT);
  localparam logic [SumW-1:0] CntMax = {1'b0, {CNT_WIDTH{1'b1}}};

  logic [63:0]          cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [OutW-1:0]      out_q, out_d;
  logic                 simv_q, simv_d;
  gfifo_err_e           err_q, err_d;

  logic                 fifo_full, fifo_empty;
  logic                 push, pop, sat, rsp_ok, proto, host_fail;
  logic [SumW-1:0]      sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic [EntryW-1:0]    wdata, rdata;

  assign host_valid = !fifo_empty && (out_q < MaxOut);
  assign pop        = host_valid && host_ready;
  assign sum        = {1'b0, acc_q} + SumW'(step);
  assign sat        = (sum > CntMax);
  assign cnt        = sat ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  // A same-cycle pop frees a slot, so a full FIFO can still take a push.
  assign push       = (sum != '0) && (!fifo_full || pop);
  assign wdata      = {cycle_q, cnt};

  assign rsp_ok     = rsp_valid && (out_q != '0);
  assign proto      = rsp_valid && (out_q == '0);
  assign host_fail  = rsp_valid && rsp_fail;

  assign host_cycle  = rdata[EntryW-1:CNT_WIDTH];
  assign host_count  = rdata[CNT_WIDTH-1:0];
  assign simv_result = simv_q;
  assign err_code    = err_q;

  gfifo_sync_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .wr_en_i   (push),
    .wr_data_i (wdata),
    .rd_en_i   (pop),
    .rd_data_o (rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    cycle_d = cycle_q + 64'd1;
    acc_d   = push ? '0 : cnt;
    out_d   = out_q + OutW'(pop) - OutW'(rsp_ok);
    simv_d  = simv_q | host_fail | sat | proto;
    err_d   = err_q;
    // First error wins; among simultaneous causes host failure ranks highest.
    if (err_q == ErrNone) begin
      if (host_fail)  err_d = ErrHostFail;
      else if (sat)   err_d = ErrCntSat;
      else if (proto) err_d = ErrProto;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      simv_q  <= 1'b0;
      err_q   <= ErrNone;
    end else begin
      cycle_q <= cycle_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      simv_q  <= simv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gfifo_ctrl.sv
// Self-checking bench for gfifo_ctrl: queue-based reference model plus directed scenarios.
module tb_gfifo_ctrl;
  import gfifo_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int          MAX_OUT = 4;
  localparam int unsigned CNT_MAX = 65535;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  step;
  logic        host_valid;
  logic        host_ready;
  logic [63:0] host_cycle;
  logic [15:0] host_count;
  logic        rsp_valid;
  logic        rsp_fail;
  logic        simv_result;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  gfifo_ctrl #(
    .STEP_WIDTH (8),
    .CNT_WIDTH  (16),
    .DEPTH      (DEPTH),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .step        (step),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_cycle  (host_cycle),
    .host_count  (host_count),
    .rsp_valid   (rsp_valid),
    .rsp_fail    (rsp_fail),
    .simv_result (simv_result),
    .err_code    (err_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: entries as a queue, counters as plain integers.
  gfifo_entry_t    m_q[$];
  int unsigned     m_acc  = 0;
  longint unsigned m_cyc  = 0;
  int              m_out  = 0;
  logic            m_simv = 1'b0;
  logic [1:0]      m_err  = 2'd0;
  bit              started = 1'b0;

  always @(posedge clock) begin
    int unsigned  sum;
    bit           hv, pop, ovf, proto, fail;
    int           out0;
    gfifo_entry_t e;
    started = 1'b1;
    if (reset) begin
      m_q.delete();
      m_acc  = 0;
      m_cyc  = 0;
      m_out  = 0;
      m_simv = 1'b0;
      m_err  = 2'd0;
    end else begin
      hv   = (m_q.size() != 0) && (m_out < MAX_OUT);
      pop  = hv && host_ready;
      out0 = m_out;
      if (pop) begin
        void'(m_q.pop_front());
        m_out++;
      end
      sum = m_acc + int'(step);
      ovf = (sum > CNT_MAX);
      if (ovf) sum = CNT_MAX;
      if (sum != 0 && m_q.size() < DEPTH) begin
        e.cycle = m_cyc;
        e.count = 16'(sum);
        m_q.push_back(e);
        m_acc = 0;
      end else begin
        m_acc = sum;
      end
      fail  = rsp_valid && rsp_fail;
      proto = rsp_valid && (out0 == 0);
      if (rsp_valid && out0 > 0) m_out--;
      if (m_err == 2'd0) begin
        if (fail)       m_err = 2'd1;
        else if (ovf)   m_err = 2'd2;
        else if (proto) m_err = 2'd3;
      end
      m_simv = m_simv | fail | ovf | proto;
      m_cyc++;
    end
  end

  always @(negedge clock) begin
    bit mhv;
    if (started) begin
      mhv = (m_q.size() != 0) && (m_out < MAX_OUT);
      check("host_valid", 64'(host_valid), 64'(mhv));
      if (mhv) begin
        check("host_cycle", host_cycle, m_q[0].cycle);
        check("host_count", 64'(host_count), 64'(m_q[0].count));
      end
      check("simv_result", 64'(simv_result), 64'(m_simv));
      check("err_code", 64'(err_code), 64'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    step       = '0;
    host_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_fail   = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    step       = '0;
    host_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_fail   = 1'b0;
    cyc(2);
    reset = 1'b0;
    check("rst_host_valid", 64'(host_valid), 64'd0);
    check("rst_simv", 64'(simv_result), 64'd0);
    check("rst_err", 64'(err_code), 64'd0);

    // Single entry stamped at cycle 5, popped and passed.
    cyc(5);
    step = 8'd3;
    cyc(1);
    step = '0;
    check("t1_valid", 64'(host_valid), 64'd1);
    check("t1_cycle", host_cycle, 64'd5);
    check("t1_count", 64'(host_count), 64'd3);
    host_ready = 1'b1;
    cyc(1);
    host_ready = 1'b0;
    rsp_valid  = 1'b1;
    cyc(1);
    rsp_valid = 1'b0;
    cyc(1);
    check("t1_simv", 64'(simv_result), 64'd0);
    check("t1_err", 64'(err_code), 64'd0);

    // Fill FIFO, accumulate 3, then pop+push while full coalesces to count 4.
    do_reset();
    step = 8'd1;
    cyc(DEPTH + 3);
    check("t2_head_cycle", host_cycle, 64'd0);
    check("t2_head_count", 64'(host_count), 64'd1);
    host_ready = 1'b1;
    cyc(1);
    host_ready = 1'b0;
    step       = '0;
    cyc(1);
    host_ready = 1'b1;
    rsp_valid  = 1'b1;
    cyc(7);
    host_ready = 1'b0;
    rsp_valid  = 1'b0;
    check("t2_coal_cycle", host_cycle, 64'd11);
    check("t2_coal_count", 64'(host_count), 64'd4);

    // Saturation: bounded wait for the sticky flag.
    do_reset();
    step = 8'd255;
    n = 0;
    while (!simv_result && n < 400) begin
      cyc(1);
      n++;
    end
    step = '0;
    check("t3_sat_latency", 64'(n), 64'd266);
    check("t3_simv", 64'(simv_result), 64'd1);
    check("t3_err", 64'(err_code), 64'd2);

    // Outstanding limit stalls host_valid; one pass verdict resumes.
    do_reset();
    step = 8'd1;
    cyc(6);
    step       = '0;
    host_ready = 1'b1;
    cyc(6);
    check("t4_stalled", 64'(host_valid), 64'd0);
    rsp_valid = 1'b1;
    cyc(1);
    rsp_valid = 1'b0;
    check("t4_resumed", 64'(host_valid), 64'd1);
    check("t4_cycle", host_cycle, 64'd4);
    host_ready = 1'b0;
    cyc(1);

    // Failure on second entry; later protocol error must not override it.
    do_reset();
    step = 8'd1;
    cyc(3);
    step       = '0;
    host_ready = 1'b1;
    cyc(3);
    host_ready = 1'b0;
    rsp_valid  = 1'b1;
    cyc(1);
    check("t5_pass_simv", 64'(simv_result), 64'd0);
    rsp_fail = 1'b1;
    cyc(1);
    rsp_fail  = 1'b0;
    rsp_valid = 1'b0;
    check("t5_fail_simv", 64'(simv_result), 64'd1);
    check("t5_fail_err", 64'(err_code), 64'd1);
    rsp_valid = 1'b1;
    cyc(2);
    rsp_valid = 1'b0;
    cyc(1);
    check("t5_sticky_err", 64'(err_code), 64'd1);

    // Protocol error alone, then reset with entries queued.
    do_reset();
    rsp_valid = 1'b1;
    cyc(1);
    rsp_valid = 1'b0;
    check("t6_proto_err", 64'(err_code), 64'd3);
    step = 8'd1;
    cyc(5);
    step = '0;
    check("t6_queued", 64'(host_valid), 64'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t6_rst_valid", 64'(host_valid), 64'd0);
    check("t6_rst_simv", 64'(simv_result), 64'd0);
    check("t6_rst_err", 64'(err_code), 64'd0);
    step = 8'd2;
    cyc(1);
    step = '0;
    check("t6_cycle0", host_cycle, 64'd0);
    check("t6_count", 64'(host_count), 64'd2);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
